// File: rtl/feed_cmd_encoder.sv
// ============================================================================
// feed_cmd_encoder
// ----------------------------------------------------------------------------
// Front-end command issuer for the feeder option FSM.
//
// Three raw push-buttons (pour, stop, interval) are each synchronised with a
// 2-flop synchroniser and then debounced. A debounced rising edge becomes a
// one-cycle request. Each accepted request becomes exactly one protocol
// transaction on option/fsm_enable:
//
//   IDLE  : option = 000, fsm_enable = 0
//   ISSUE : option = code, fsm_enable = 0   (one setup cycle)
//   HOLD  : option = code, fsm_enable = 1   (HOLD_CYCLES cycles)
//   GAP   : option = code, fsm_enable = 0   (one release cycle)
//
// The code is set up one cycle before the strobe and held one cycle after
// it, so the consumer (which idles every second cycle) always samples a
// stable code. Requests that arrive while busy go to a one-deep pending
// slot. A higher-priority request may overwrite the slot; anything else is
// dropped. Priority is stop > pour > interval.
//
// Parameters:
//   DEBOUNCE_CYCLES : stable synchronised samples before a level flips
//                     (2..65535)
//   HOLD_CYCLES     : cycles fsm_enable is held high per command (2..255)
//
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous, active-high reset
//   btn_pour     in   raw pour button, asynchronous
//   btn_stop     in   raw stop button, asynchronous
//   btn_interval in   raw interval button, asynchronous
//   option       out  [2:0] command code (000 none, 001 pour, 010 stop,
//                     011 interval)
//   fsm_enable   out  command strobe to the option FSM
//   busy         out  high whenever the issuer is not idle
//   cmd_count    out  [7:0] number of issued commands
//
// Optional feature (macro FEED_CMD_COUNT_EN):
//   When defined, cmd_count counts transitions into HOLD. It is 8 bits wide,
//   wraps from 255 to 0 and is cleared only by reset. When undefined,
//   cmd_count is tied to zero and no counter flops are built.
// ============================================================================
module feed_cmd_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_pour,
    input  logic       btn_stop,
    input  logic       btn_interval,
    output logic [2:0] option,
    output logic       fsm_enable,
    output logic       busy,
    output logic [7:0] cmd_count
);

    // ------------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        CODE_NONE     = 3'b000,
        CODE_POUR     = 3'b001,
        CODE_STOP     = 3'b010,
        CODE_INTERVAL = 3'b011
    } cmd_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Button lane indices within the packed button vectors.
    localparam int BTN_POUR     = 0;
    localparam int BTN_STOP     = 1;
    localparam int BTN_INTERVAL = 2;

    localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);

    // Priority rank of a code: a larger value wins. NONE never wins.
    function automatic logic [1:0] code_rank(input cmd_code_t code);
        case (code)
            CODE_STOP:     code_rank = 2'd3;
            CODE_POUR:     code_rank = 2'd2;
            CODE_INTERVAL: code_rank = 2'd1;
            default:       code_rank = 2'd0;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Synchronise and debounce each button
    // ------------------------------------------------------------------------
    logic [2:0] btn_raw;
    logic [2:0] btn_req;

    assign btn_raw[BTN_POUR]     = btn_pour;
    assign btn_raw[BTN_STOP]     = btn_stop;
    assign btn_raw[BTN_INTERVAL] = btn_interval;

    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic        sync_a;
        logic        sync_b;
        logic        level;
        logic        level_prev;
        logic [15:0] stable_cnt;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sync_a     <= 1'b0;
                sync_b     <= 1'b0;
                level      <= 1'b0;
                level_prev <= 1'b0;
                // NOTE: the debounce counter is reset together with the level.
                // A count left over from before reset could otherwise shorten
                // the first debounce window after reset.
                stable_cnt <= '0;
            end else begin
                // NOTE: non-blocking assignments make sync_b take the old
                // sync_a, which is what gives two real flop stages. Blocking
                // assignments here would collapse the chain into one flop.
                sync_a     <= btn_raw[i];
                sync_b     <= sync_a;
                level_prev <= level;

                if (sync_b == level) begin
                    stable_cnt <= '0;
                end else if (stable_cnt == DEB_LAST) begin
                    // The sample after DEBOUNCE_CYCLES-1 differing samples is
                    // the DEBOUNCE_CYCLES-th, so the level flips here.
                    level      <= ~level;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 16'd1;
                end
            end
        end

        // Only rising edges of the debounced level create requests.
        assign btn_req[i] = level & ~level_prev;
    end

    // ------------------------------------------------------------------------
    // Request arbitration: stop > pour > interval; losers are discarded
    // ------------------------------------------------------------------------
    logic      req_valid;
    cmd_code_t req_code;

    always_comb begin
        // NOTE: every signal gets a default before the branches. Without a
        // default, a path that leaves a signal unassigned would make the tool
        // infer a latch.
        req_valid = |btn_req;
        req_code  = CODE_NONE;
        if (btn_req[BTN_STOP]) begin
            req_code = CODE_STOP;
        end else if (btn_req[BTN_POUR]) begin
            req_code = CODE_POUR;
        end else if (btn_req[BTN_INTERVAL]) begin
            req_code = CODE_INTERVAL;
        end
    end

    // ------------------------------------------------------------------------
    // Command sequencer state
    // ------------------------------------------------------------------------
    state_t    state,      state_next;
    cmd_code_t code,       code_next;
    logic      slot_valid, slot_valid_next;
    cmd_code_t slot_code,  slot_code_next;
    logic [7:0] hold_cnt,  hold_cnt_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            code       <= CODE_NONE;
            slot_valid <= 1'b0;
            slot_code  <= CODE_NONE;
            hold_cnt   <= '0;
        end else begin
            state      <= state_next;
            code       <= code_next;
            slot_valid <= slot_valid_next;
            slot_code  <= slot_code_next;
            hold_cnt   <= hold_cnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic and pending slot handling
    // ------------------------------------------------------------------------
    logic slot_consumed;
    logic slot_live;
    logic req_to_slot;

    always_comb begin
        state_next      = state;
        code_next       = code;
        hold_cnt_next   = hold_cnt;
        slot_consumed   = 1'b0;
        slot_valid_next = slot_valid;
        slot_code_next  = slot_code;
        slot_live       = slot_valid;
        req_to_slot     = 1'b0;

        case (state)
            ST_IDLE: begin
                // A stored command takes precedence over a fresh request.
                if (slot_valid) begin
                    code_next     = slot_code;
                    slot_consumed = 1'b1;
                    state_next    = ST_ISSUE;
                end else if (req_valid) begin
                    code_next  = req_code;
                    state_next = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                hold_cnt_next = '0;
                state_next    = ST_HOLD;
            end

            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next = ST_GAP;
                end else begin
                    hold_cnt_next = hold_cnt + 8'd1;
                end
            end

            ST_GAP: begin
                // Chain straight into the next command if one is waiting,
                // so there is no idle cycle between back-to-back commands.
                if (slot_valid) begin
                    code_next     = slot_code;
                    slot_consumed = 1'b1;
                    state_next    = ST_ISSUE;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A slot consumed this cycle counts as empty for a request that
        // arrives in the same cycle.
        slot_live       = slot_valid & ~slot_consumed;
        slot_valid_next = slot_live;

        // A request goes to the slot unless it was taken directly from an
        // empty IDLE.
        req_to_slot = req_valid && ((state != ST_IDLE) || slot_valid);

        if (req_to_slot) begin
            if (!slot_live || (code_rank(req_code) > code_rank(slot_code))) begin
                slot_valid_next = 1'b1;
                slot_code_next  = req_code;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded from registered state only. Reset forces them low
    // asynchronously because the state register resets asynchronously.
    // ------------------------------------------------------------------------
    assign option     = (state == ST_IDLE) ? CODE_NONE : code;
    assign fsm_enable = (state == ST_HOLD);
    assign busy       = (state != ST_IDLE);

    // ------------------------------------------------------------------------
    // Issued-command counter
    // ------------------------------------------------------------------------
`ifdef FEED_CMD_COUNT_EN
    logic [7:0] cmd_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_count_q <= '0;
        end else if ((state_next == ST_HOLD) && (state != ST_HOLD)) begin
            cmd_count_q <= cmd_count_q + 8'd1;   // wraps 255 -> 0
        end
    end

    assign cmd_count = cmd_count_q;
`else
    assign cmd_count = 8'd0;
`endif

endmodule

// File: tb/tb_feed_cmd_encoder.sv
// ============================================================================
// tb_feed_cmd_encoder
// ----------------------------------------------------------------------------
// Self-checking bench for feed_cmd_encoder with DEBOUNCE_CYCLES = 4 and
// HOLD_CYCLES = 2.
//
// A negedge monitor records every command (the option value seen when
// fsm_enable rises). It also checks the protocol on every cycle: the strobe
// length, option stability under the strobe, the GAP code, the busy/option
// relation and cmd_count.
//
// The expected command for a burst of presses is derived from the rules:
//   - a button held for at least DEBOUNCE_CYCLES samples produces a request;
//   - among buttons that request together, stop > pour > interval wins.
// ============================================================================
module tb_feed_cmd_encoder;

    localparam int DEB  = 4;
    localparam int HOLD = 2;

    logic       clock        = 1'b0;
    logic       reset        = 1'b1;
    logic       btn_pour     = 1'b0;
    logic       btn_stop     = 1'b0;
    logic       btn_interval = 1'b0;
    logic [2:0] option;
    logic       fsm_enable;
    logic       busy;
    logic [7:0] cmd_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    feed_cmd_encoder #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_pour    (btn_pour),
        .btn_stop    (btn_stop),
        .btn_interval(btn_interval),
        .option      (option),
        .fsm_enable  (fsm_enable),
        .busy        (busy),
        .cmd_count   (cmd_count)
    );

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Protocol monitor
    // ------------------------------------------------------------------------
    logic [2:0] cap_q[$];
    logic       en_prev   = 1'b0;
    logic [2:0] run_code  = 3'b000;
    int         run_len   = 0;
    int         model_cnt = 0;

    always @(negedge clock) begin
        if (reset) begin
            en_prev   = 1'b0;
            run_len   = 0;
            model_cnt = 0;
        end else begin
            check("busy_vs_option", busy, option != 3'b000);
            if (fsm_enable) begin
                if (!en_prev) begin
                    cap_q.push_back(option);
                    run_code  = option;
                    run_len   = 0;
                    model_cnt = (model_cnt + 1) % 256;
`ifdef FEED_CMD_COUNT_EN
                    check("cmd_count", cmd_count, model_cnt);
`endif
                end
                check("option_stable", option, run_code);
                run_len++;
            end else if (en_prev) begin
                check("hold_len", run_len, HOLD);
                check("gap_option", option, run_code);
                check("gap_busy", busy, 1);
            end
`ifndef FEED_CMD_COUNT_EN
            check("cmd_count_tied", cmd_count, 0);
`endif
            en_prev = fsm_enable;
        end
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Raise the selected buttons on the same edge. Each one stays high for
    // its own number of sampled cycles (0 = not pressed).
    task automatic press_multi(input int len_p, input int len_s, input int len_i);
        int max_len;
        max_len = len_p;
        if (len_s > max_len) max_len = len_s;
        if (len_i > max_len) max_len = len_i;
        @(negedge clock);
        btn_pour     = (len_p > 0);
        btn_stop     = (len_s > 0);
        btn_interval = (len_i > 0);
        for (int t = 1; t <= max_len; t++) begin
            @(negedge clock);
            if (t == len_p) btn_pour     = 1'b0;
            if (t == len_s) btn_stop     = 1'b0;
            if (t == len_i) btn_interval = 1'b0;
        end
    endtask

    // Expected command from the rules, not from the RTL structure.
    function automatic logic [2:0] expected_code(input int len_p, input int len_s,
                                                 input int len_i);
        if (len_s >= DEB) return 3'b010;
        if (len_p >= DEB) return 3'b001;
        if (len_i >= DEB) return 3'b011;
        return 3'b000;
    endfunction

    task automatic expect_cmds(input string name, input int n,
                               input logic [2:0] c0, input logic [2:0] c1);
        logic [2:0] exp_c;
        check({name, "_count"}, cap_q.size(), n);
        for (int i = 0; i < n && i < cap_q.size(); i++) begin
            exp_c = (i == 0) ? c0 : c1;
            check({name, "_code"}, cap_q[i], exp_c);
        end
        cap_q.delete();
    endtask

    // ------------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------------
    typedef struct {
        int         len_p;
        int         len_s;
        int         len_i;
        int         n_cmds;
        logic [2:0] code;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ec;
        int         lp, ls, li;
        bit         seen;

        vecs[0]  = '{20, 0, 0, 1, 3'b001};  // pour
        vecs[1]  = '{0, 20, 0, 1, 3'b010};  // stop
        vecs[2]  = '{0, 0, 20, 1, 3'b011};  // interval
        vecs[3]  = '{20, 0, 20, 1, 3'b001}; // pour + interval
        vecs[4]  = '{20, 20, 0, 1, 3'b010}; // pour + stop
        vecs[5]  = '{0, 20, 20, 1, 3'b010}; // stop + interval
        vecs[6]  = '{20, 20, 20, 1, 3'b010};// all three
        vecs[7]  = '{0, 2, 0, 0, 3'b000};   // short glitch
        vecs[8]  = '{3, 0, 0, 0, 3'b000};   // one sample too short
        vecs[9]  = '{4, 0, 0, 1, 3'b001};   // exactly DEB samples
        vecs[10] = '{8, 3, 0, 1, 3'b001};   // short stop never requests

        // ---- Test 1: reset with buttons toggling ---------------------------
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            btn_pour     = $urandom_range(0, 1);
            btn_stop     = $urandom_range(0, 1);
            btn_interval = $urandom_range(0, 1);
            #1;
            check("rst_option", option, 3'b000);
            check("rst_enable", fsm_enable, 0);
            check("rst_busy", busy, 0);
            check("rst_count", cmd_count, 0);
        end
        @(negedge clock);
        btn_pour = 1'b0; btn_stop = 1'b0; btn_interval = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            check("idle_option", option, 3'b000);
            check("idle_enable", fsm_enable, 0);
        end
        expect_cmds("idle", 0, 3'b000, 3'b000);

        // ---- Test 2: single press, exact latency and shape ------------------
        @(negedge clock);
        btn_pour = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clock);
            case (k)
                6: begin
                    check("lat_early_busy", busy, 0);
                    check("lat_early_opt", option, 3'b000);
                end
                7: begin
                    check("issue_opt", option, 3'b001);
                    check("issue_en", fsm_enable, 0);
                    check("issue_busy", busy, 1);
                end
                8, 9: begin
                    check("hold_en", fsm_enable, 1);
                    check("hold_opt", option, 3'b001);
                end
                10: begin
                    check("gap_en", fsm_enable, 0);
                    check("gap_opt", option, 3'b001);
                end
                11: begin
                    check("end_opt", option, 3'b000);
                    check("end_busy", busy, 0);
                end
                default: ;
            endcase
        end
        cycles(9);
        btn_pour = 1'b0;
        cycles(30);
        expect_cmds("single", 1, 3'b001, 3'b000);

        // ---- Test 3: glitch 2 high, 1 low, 2 high ---------------------------
        @(negedge clock); btn_stop = 1'b1;
        cycles(2);        btn_stop = 1'b0;
        cycles(1);        btn_stop = 1'b1;
        cycles(2);        btn_stop = 1'b0;
        cycles(30);
        expect_cmds("glitch", 0, 3'b000, 3'b000);

        // ---- Table-driven vectors -------------------------------------------
        foreach (vecs[i]) begin
            press_multi(vecs[i].len_p, vecs[i].len_s, vecs[i].len_i);
            cycles(45);
            expect_cmds($sformatf("vec%0d", i), vecs[i].n_cmds, vecs[i].code, 3'b000);
        end

        // ---- Test 5: pending slot with replacement, no idle gap ----------
        @(negedge clock);
        btn_interval = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (k == 1) btn_pour = 1'b1;
            if (k == 3) btn_stop = 1'b1;
            if (k == 10) begin
                check("pend_gap_opt", option, 3'b011);
                check("pend_gap_en", fsm_enable, 0);
            end
            if (k == 11) begin
                check("pend_next_opt", option, 3'b010);
                check("pend_next_busy", busy, 1);
            end
        end
        btn_interval = 1'b0; btn_pour = 1'b0; btn_stop = 1'b0;
        cycles(40);
        expect_cmds("pending", 2, 3'b011, 3'b010);

        // ---- Test 6: reset mid-HOLD, button held through reset -------------
        @(negedge clock);
        btn_pour = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clock);
            if (fsm_enable) seen = 1'b1;
        end
        check("wait_hold", seen, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_en", fsm_enable, 0);
        check("rst_mid_opt", option, 3'b000);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_count", cmd_count, 0);
        cycles(3);
        reset = 1'b0;
        cap_q.delete();
        cycles(30);
        expect_cmds("held_thru_rst", 1, 3'b001, 3'b000);
        btn_pour = 1'b0;
        cycles(20);
        expect_cmds("release_after_rst", 0, 3'b000, 3'b000);

`ifdef FEED_CMD_COUNT_EN
        // ---- Counter wrap: 256 presses return the count to 0 ----------------
        @(negedge clock); reset = 1'b1;
        cycles(2);        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            press_multi(6, 0, 0);
            cycles(20);
        end
        check("wrap_cmds", cap_q.size(), 256);
        check("wrap_count", cmd_count, 0);
        cap_q.delete();
`endif

        // ---- Randomized bursts against the rule-based model -------------
        for (int it = 0; it < 40; it++) begin
            lp = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 12)) : 0;
            ls = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 12)) : 0;
            li = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 12)) : 0;
            ec = expected_code(lp, ls, li);
            press_multi(lp, ls, li);
            cycles(40);
            expect_cmds($sformatf("rand%0d", it), (ec != 3'b000) ? 1 : 0, ec, 3'b000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/feed_cmd_encoder.md
Name: feed_cmd_encoder

Overview:
- Front-end command issuer for the feeder option FSM.
- Takes three raw push-buttons (pour, stop, interval) and synchronises and debounces each one.
- Turns each press into a single protocol transaction on option[2:0] / fsm_enable.
- Sequences option setup, enable hold and release so that the option FSM is guaranteed to sample the command while in its idle state.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples required before a debounced level changes; legal range 2..65535.
- HOLD_CYCLES, 2: cycles fsm_enable is held high per command; legal range 2..255. A minimum of 2 guarantees capture by the consumer, which idles every second cycle.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- btn_pour, input, 1: raw pour button, active-high, asynchronous to clock.
- btn_stop, input, 1: raw stop button, active-high, asynchronous.
- btn_interval, input, 1: raw interval button, active-high, asynchronous.
- option, output, 3: command code. 3'b000 = none, 3'b001 = pour, 3'b010 = stop, 3'b011 = interval.
- fsm_enable, output, 1: command strobe to the option FSM.
- busy, output, 1: high in any state other than IDLE.
- cmd_count, output, 8: number of issued commands (see Optional Feature).

Behaviour:
- Reset values:
  - option = 3'b000, fsm_enable = 0, busy = 0, cmd_count = 0.
  - State = IDLE, pending slot empty.
  - Synchronisers, debounced levels and debounce counters = 0.
- Synchroniser: 2-flop synchroniser per button.
- Debounce, per button:
  - Counter increments each cycle the synchronised value differs from the debounced level.
  - Counter clears to 0 on any cycle where they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level toggles and the counter clears.
- Request: a debounced rising edge (debounced & ~debounced_prev) creates a one-cycle request. Falling edges create nothing.
- Latency: raw high first sampled at edge E0 → debounced high at edge E0+DEBOUNCE_CYCLES+1 → state = ISSUE at edge E0+DEBOUNCE_CYCLES+2.
- Simultaneous requests in one cycle: stop > pour > interval. Only the winner is accepted; losers are discarded.
- State machine:
  - IDLE: option = 000, fsm_enable = 0. A request (or a non-empty pending slot, which takes precedence) latches the code → ISSUE.
  - ISSUE: option = code, fsm_enable = 0. One setup cycle, then → HOLD.
  - HOLD: option = code, fsm_enable = 1 for exactly HOLD_CYCLES cycles, then → GAP.
  - GAP: option = code, fsm_enable = 0 for one cycle. Then → ISSUE if the pending slot is full (slot cleared, its code latched); otherwise → IDLE.
- Option stability: option never changes while fsm_enable = 1. option changes only on IDLE→ISSUE or GAP→ISSUE transitions, and to 000 on GAP→IDLE.
- Requests while busy, one-deep pending slot:
  - Empty slot: the request is stored.
  - Full slot: the request replaces the stored code only if it has strictly higher priority; otherwise it is dropped.
  - A request in the same cycle the slot is consumed (GAP→ISSUE) is evaluated against the now-empty slot.
- Reset mid-operation: everything returns to reset values immediately. fsm_enable drops asynchronously and the pending slot is lost.
- Button held through reset: produces a new command once debounced after reset deassertion.
- Glitches: pulses shorter than DEBOUNCE_CYCLES synchronised cycles produce no request.

Optional Feature:
- Macro: FEED_CMD_COUNT_EN.
- Defined: cmd_count increments by 1 on every transition into HOLD. It is 8-bit and wraps 255 → 0. It is not saturating and is cleared only by reset.
- Undefined: cmd_count is tied to 8'd0, no counter flops are synthesised, and the port remains present.

Test Plan (DEBOUNCE_CYCLES = 4, HOLD_CYCLES = 2):
1. Reset: reset high 5 cycles with buttons toggling → option = 000, fsm_enable = 0, busy = 0, cmd_count = 0 throughout. After release with no buttons pressed, outputs stay idle for 50 cycles.
2. Single press: btn_pour high 20 cycles → ISSUE at E0+6 with option = 001 and fsm_enable = 0. Then fsm_enable = 1 for exactly 2 cycles, one GAP cycle with option = 001, then option = 000 and busy = 0. Exactly one command issued.
3. Glitch rejection: btn_stop pulses 2 cycles high, 1 low, 2 high → no ISSUE, option stays 000.
4. Simultaneous press: btn_pour and btn_interval rise on the same edge → only option = 001 issued; the interval request is discarded.
5. Pending and priority: press interval; during its HOLD press pour, then stop → after GAP, ISSUE with 010 (stop replaced pour). No 001 command appears, and no idle cycle occurs between the commands.
6. Reset mid-HOLD plus counter: assert reset while fsm_enable = 1 → fsm_enable = 0 in the same cycle. With FEED_CMD_COUNT_EN, 256 pour presses → cmd_count returns to 0. Without the macro, cmd_count = 0 at all times.
